// File: rtl/shift_sub_divider_pkg.sv
// Shared types and constants for the shift-subtract divider.
// The FIX state is only reached when SHIFT_SUB_DIVIDER_SIGNED_EN is defined.
package shift_sub_divider_pkg;

  // Controller states; FIX sits between CALC and DONE for signed operations.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Legal operand widths.
  localparam int DIV_MIN_WIDTH = 2;
  localparam int DIV_MAX_WIDTH = 32;

  // Iteration counter must hold the value WIDTH itself.
  function automatic int div_count_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_sub_divider_sub_stage.sv
// One restoring-division step: trial subtract of the divisor from the
// shifted partial remainder, keeping the difference only when it does
// not borrow. Purely combinational.
module div_sub_stage #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   p_shifted,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   p_next,
  output logic             q_bit
);

  logic [WIDTH:0] trial;

  // The partial remainder stays below 2*divisor, so the difference always
  // fits in WIDTH+1 bits and its MSB is a clean borrow indicator.
  always_comb begin
    trial  = p_shifted - {1'b0, divisor};
    q_bit  = ~trial[WIDTH];
    p_next = q_bit ? trial : p_shifted;
  end

endmodule

// File: rtl/shift_sub_divider.sv
// Sequential restoring (shift-subtract) unsigned divider, one quotient bit
// per clock, with start/busy/done handshake.
// Optional feature macro: SHIFT_SUB_DIVIDER_SIGNED_EN adds a signed_op input
// and a one-cycle FIX state that applies operand signs to the results.
module shift_sub_divider
  import shift_sub_divider_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
  input  logic             signed_op,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int              CW        = div_count_w(WIDTH);
  localparam logic [CW-1:0]   CNT_INIT  = CW'(WIDTH);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);

  if (WIDTH < DIV_MIN_WIDTH || WIDTH > DIV_MAX_WIDTH) begin : g_width_check
    $error("shift_sub_divider: WIDTH out of range");
  end

  // Two's-complement negate, used for operand magnitudes and result signs.
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return (~v) + ONE_W;
  endfunction

  div_state_e       state;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   p_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] divisor_reg;
  logic [WIDTH-1:0] dividend_reg;
  logic             zero_pend;

  logic [WIDTH:0]   p_shifted;
  logic [WIDTH:0]   p_next;
  logic [WIDTH-1:0] q_shifted;
  logic             q_bit;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;

`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
  logic fix_en;
  logic neg_q;
  logic neg_r;

  // Magnitudes of the operands when a signed division is requested.
  always_comb begin
    dividend_mag = dividend;
    divisor_mag  = divisor;
    if (signed_op && dividend[WIDTH-1]) dividend_mag = negate(dividend);
    if (signed_op && divisor[WIDTH-1])  divisor_mag  = negate(divisor);
  end
`else
  // Unsigned build: operands are used as-is.
  always_comb begin
    dividend_mag = dividend;
    divisor_mag  = divisor;
  end
`endif

  // Shift {P,Q} left by one and append the new quotient bit.
  always_comb begin
    p_shifted = {p_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    q_shifted = {q_reg[WIDTH-2:0], q_bit};
  end

  div_sub_stage #(
    .WIDTH (WIDTH)
  ) u_sub_stage (
    .p_shifted (p_shifted),
    .divisor   (divisor_reg),
    .p_next    (p_next),
    .q_bit     (q_bit)
  );

  // Controller and datapath registers; outputs are registered and only
  // change on entry to DONE (or on reset).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      count        <= '0;
      p_reg        <= '0;
      q_reg        <= '0;
      divisor_reg  <= '0;
      dividend_reg <= '0;
      zero_pend    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      quotient     <= '0;
      remainder    <= '0;
      div_by_zero  <= 1'b0;
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
      fix_en       <= 1'b0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dividend_reg <= dividend;
            divisor_reg  <= divisor_mag;
            p_reg        <= '0;
            busy         <= 1'b1;
            state        <= CALC;
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
            fix_en       <= signed_op;
            neg_q        <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r        <= signed_op & dividend[WIDTH-1];
`endif
            // A zero divisor spends a single cycle in CALC without iterating,
            // so its done pulse lands one cycle after acceptance.
            if (divisor == '0) begin
              zero_pend <= 1'b1;
              count     <= CNT_ONE;
              q_reg     <= '0;
            end else begin
              zero_pend <= 1'b0;
              count     <= CNT_INIT;
              q_reg     <= dividend_mag;
            end
          end
        end

        CALC: begin
          if (zero_pend) begin
            zero_pend   <= 1'b0;
            count       <= '0;
            state       <= DONE;
            done        <= 1'b1;
            quotient    <= '1;
            remainder   <= dividend_reg;
            div_by_zero <= 1'b1;
          end else begin
            p_reg <= p_next;
            q_reg <= q_shifted;
            count <= count - CNT_ONE;
            if (count == CNT_ONE) begin
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
              if (fix_en) begin
                state <= FIX;
              end else begin
                state       <= DONE;
                done        <= 1'b1;
                quotient    <= q_shifted;
                remainder   <= p_next[WIDTH-1:0];
                div_by_zero <= 1'b0;
              end
`else
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= q_shifted;
              remainder   <= p_next[WIDTH-1:0];
              div_by_zero <= 1'b0;
`endif
            end
          end
        end

`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
        FIX: begin
          // Quotient truncates toward zero; remainder follows the dividend.
          // Most-negative / -1 wraps naturally through the negate.
          state       <= DONE;
          done        <= 1'b1;
          quotient    <= neg_q ? negate(q_reg) : q_reg;
          remainder   <= neg_r ? negate(p_reg[WIDTH-1:0]) : p_reg[WIDTH-1:0];
          div_by_zero <= 1'b0;
        end
`endif

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sub_divider.sv
// Self-checking bench for shift_sub_divider (WIDTH=8): vector table,
// hand sequences for handshake corners, and randomized operands against
// a plain-arithmetic reference model.
module tb_shift_sub_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         dz;
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
  logic         signed_op = 1'b0;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           lat;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  shift_sub_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
    .signed_op   (signed_op),
`endif
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (dz)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Issue one division and wait for its done pulse; lat counts rising
  // edges after the accepting edge.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sop,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic z, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    start    = 1'b1;
    dividend = a;
    divisor  = b;
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
    signed_op = sop;
`else
    if (sop) $display("note: signed request ignored in unsigned build");
`endif
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!done && lat < 100);
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected a done pulse", lat);
    end
    q = quotient;
    r = remainder;
    z = dz;
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
    signed_op = 1'b0;
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] q, r, eq, er;
    logic         z, ez;
    int           lat, elat, ndone;

    vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 8};
    vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 8};
    vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 8};
    vecs[3] = '{8'd42,  8'd0,   8'hFF,  8'd42,  1'b1, 1};
    vecs[4] = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0, 8};
    vecs[5] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 8};
    vecs[6] = '{8'd128, 8'd2,   8'd64,  8'd0,   1'b0, 8};
    vecs[7] = '{8'd1,   8'd255, 8'd0,   8'd1,   1'b0, 8};
    vecs[8] = '{8'd254, 8'd16,  8'd15,  8'd14,  1'b0, 8};
    vecs[9] = '{8'd0,   8'd0,   8'hFF,  8'd0,   1'b1, 1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_quotient", {24'd0, quotient}, 32'd0);
    check("reset_remainder", {24'd0, remainder}, 32'd0);
    check("reset_dz", {31'd0, dz}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_busy", {31'd0, busy}, 32'd0);

    // Vector table
    for (int i = 0; i < 10; i++) begin
      run_div(vecs[i].a, vecs[i].b, 1'b0, q, r, z, lat);
      check($sformatf("vec%0d_quotient", i), {24'd0, q}, {24'd0, vecs[i].q});
      check($sformatf("vec%0d_remainder", i), {24'd0, r}, {24'd0, vecs[i].r});
      check($sformatf("vec%0d_dz", i), {31'd0, z}, {31'd0, vecs[i].z});
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_done_pulse", i), {31'd0, done}, 32'd0);
      check($sformatf("vec%0d_busy_after", i), {31'd0, busy}, 32'd0);
    end

    // Results hold until the next accepted start
    run_div(8'd5, 8'd9, 1'b0, q, r, z, lat);
    dividend = 8'd77;
    divisor  = 8'd3;
    repeat (6) @(posedge clk);
    #1;
    check("hold_quotient", {24'd0, quotient}, 32'd0);
    check("hold_remainder", {24'd0, remainder}, 32'd5);

    // Start while busy is ignored
    @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 8'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; dividend = 8'd9; divisor = 8'd4;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    q = '0;
    r = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        q = quotient;
        r = remainder;
      end
    end
    check("busy_start_done_count", ndone, 1);
    check("busy_start_quotient", {24'd0, q}, 32'd66);
    check("busy_start_remainder", {24'd0, r}, 32'd2);

    // Reset in the middle of CALC
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_done", {31'd0, done}, 32'd0);
    check("midreset_quotient", {24'd0, quotient}, 32'd0);
    check("midreset_remainder", {24'd0, remainder}, 32'd0);
    check("midreset_dz", {31'd0, dz}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("midreset_no_done", ndone, 0);
    run_div(8'd50, 8'd5, 1'b0, q, r, z, lat);
    check("after_reset_quotient", {24'd0, q}, 32'd10);
    check("after_reset_remainder", {24'd0, r}, 32'd0);

    // Randomized operands against arithmetic reference
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      a = W'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
      if (b == 0) begin
        eq = '1; er = a; ez = 1'b1; elat = 1;
      end else begin
        eq = a / b; er = a % b; ez = 1'b0; elat = W;
      end
      run_div(a, b, 1'b0, q, r, z, lat);
      check($sformatf("rand%0d_q(%0d/%0d)", i, a, b), {24'd0, q}, {24'd0, eq});
      check($sformatf("rand%0d_r(%0d/%0d)", i, a, b), {24'd0, r}, {24'd0, er});
      check($sformatf("rand%0d_dz", i), {31'd0, z}, {31'd0, ez});
      check($sformatf("rand%0d_lat", i), lat, elat);
    end

`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
    // Signed operations
    run_div(8'hF9, 8'h02, 1'b1, q, r, z, lat);
    check("signed_m7_2_quotient", {24'd0, q}, 32'hFD);
    check("signed_m7_2_remainder", {24'd0, r}, 32'hFF);
    check("signed_m7_2_latency", lat, W + 1);
    run_div(8'h80, 8'hFF, 1'b1, q, r, z, lat);
    check("signed_min_m1_quotient", {24'd0, q}, 32'h80);
    check("signed_min_m1_remainder", {24'd0, r}, 32'h00);
    run_div(8'hF9, 8'h00, 1'b1, q, r, z, lat);
    check("signed_dz_quotient", {24'd0, q}, 32'hFF);
    check("signed_dz_remainder", {24'd0, r}, 32'hF9);
    check("signed_dz_flag", {31'd0, z}, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
